// File: rtl/sram_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : sram_burst_ctrl_if
// Brief   : Request / write-data / read-data bundle of the SRAM burst controller.
// Revision: 1.0 - initial release
// ============================================================================
interface sram_burst_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 21,
   parameter int LEN_W  = 3
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              done;

   modport master (
      output req_valid, req_write, req_addr, req_len, wr_valid, wr_data,
      input  req_ready, wr_ready, rd_valid, rd_data, busy, done
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data,
      output req_ready, wr_ready, rd_valid, rd_data, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_burst_ctrl
// Brief   : Burst word read/write controller for an async byte-wide SRAM.
// Revision: 1.0 - initial release
// ============================================================================
module sram_burst_ctrl #(
   parameter int DATA_W    = 16,
   parameter int MEM_DW    = 8,
   parameter int ADDR_W    = 21,
   parameter int WAIT_CYC  = 0,
   parameter int MAX_BURST = 4
) (
   input  wire logic         clk,
   input  wire logic         reset,
   sram_burst_ctrl_if.slave  bus,
   inout  wire [MEM_DW-1:0]  sram_data,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_ce_n,
   output logic              sram_we_n,
   output logic              sram_oe_n
);
   localparam int c_bytes  = DATA_W / MEM_DW;
   localparam int c_len_w  = $clog2(MAX_BURST) + 1;
   localparam int c_byte_w = (c_bytes > 1) ? $clog2(c_bytes) : 1;
   localparam int c_wait_w = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

   localparam logic [c_byte_w-1:0] c_byte_last = c_byte_w'(c_bytes - 1);
   localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(WAIT_CYC);
   localparam logic [c_len_w-1:0]  c_len_max   = c_len_w'(MAX_BURST);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WDATA = 3'd1,
      S_WSTRB = 3'd2,
      S_WHOLD = 3'd3,
      S_RACC  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [c_len_w-1:0]  r_len_m1;
   logic [c_len_w-1:0]  r_word;
   logic [c_byte_w-1:0] r_byte;
   logic [c_wait_w-1:0] r_wait;
   logic [DATA_W-1:0]   r_wbuf;
   logic [DATA_W-1:0]   r_rbuf;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_rd_valid;

   logic [c_len_w-1:0]  w_len_m1;
   logic [DATA_W-1:0]   w_rword;
   logic [MEM_DW-1:0]   w_wbyte;
   logic                w_byte_end;
   logic                w_last_byte;
   logic                w_last_word;
   logic                w_ce_n;
   logic                w_we_n;
   logic                w_oe_n;
   logic                w_drive;
   logic                w_wr_ready;
   logic                w_busy;
   logic                w_done;

   assign w_byte_end  = (r_wait == c_wait_last);
   assign w_last_byte = (r_byte == c_byte_last);
   assign w_last_word = (r_word == r_len_m1);

   // Zero-length requests behave as one word; oversize ones saturate.
   always_comb begin
      if (bus.req_len == '0) begin
         w_len_m1 = '0;
      end else if (bus.req_len > c_len_max) begin
         w_len_m1 = c_len_max - c_len_w'(1);
      end else begin
         w_len_m1 = bus.req_len - c_len_w'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_ce_n     = 1'b0;
      w_we_n     = 1'b1;
      w_oe_n     = 1'b1;
      w_drive    = 1'b0;
      w_wr_ready = 1'b0;
      w_busy     = 1'b1;
      w_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ce_n = 1'b1;
            w_busy = 1'b0;
            if (bus.req_valid) begin
               w_next = bus.req_write ? S_WDATA : S_RACC;
            end
         end
         S_WDATA: begin
            w_drive    = 1'b1;
            w_wr_ready = 1'b1;
            if (bus.wr_valid) begin
               w_next = S_WSTRB;
            end
         end
         S_WSTRB: begin
            w_drive = 1'b1;
            w_we_n  = 1'b0;
            if (w_byte_end) begin
               w_next = S_WHOLD;
            end
         end
         S_WHOLD: begin
            w_drive = 1'b1;
            if (!w_last_byte) begin
               w_next = S_WSTRB;
            end else if (!w_last_word) begin
               w_next = S_WDATA;
            end else begin
               w_next = S_DONE;
            end
         end
         S_RACC: begin
            w_oe_n = 1'b0;
            if (w_byte_end && w_last_byte && w_last_word) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_ce_n = 1'b1;
            w_busy = 1'b0;
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_ce_n = 1'b1;
            w_busy = 1'b0;
            w_next = S_IDLE;
         end
      endcase
   end

   // Incoming bus byte dropped into its little-endian lane of the word.
   always_comb begin
      w_rword = r_rbuf;
      w_rword[int'(r_byte)*MEM_DW +: MEM_DW] = sram_data;
   end

   assign w_wbyte = r_wbuf[int'(r_byte)*MEM_DW +: MEM_DW];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sram_addr  <= '0;
         r_len_m1   <= '0;
         r_word     <= '0;
         r_byte     <= '0;
         r_wait     <= '0;
         r_wbuf     <= '0;
         r_rbuf     <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  sram_addr <= bus.req_addr;
                  r_len_m1  <= w_len_m1;
                  r_word    <= '0;
                  r_byte    <= '0;
                  r_wait    <= '0;
               end
            end
            S_WDATA: begin
               if (bus.wr_valid) begin
                  r_wbuf <= bus.wr_data;
                  r_byte <= '0;
                  r_wait <= '0;
               end
            end
            S_WSTRB: begin
               r_wait <= w_byte_end ? '0 : r_wait + c_wait_w'(1);
            end
            S_WHOLD: begin
               sram_addr <= sram_addr + ADDR_W'(1);
               if (w_last_byte) begin
                  r_byte <= '0;
                  r_word <= r_word + c_len_w'(1);
               end else begin
                  r_byte <= r_byte + c_byte_w'(1);
               end
            end
            S_RACC: begin
               if (w_byte_end) begin
                  r_wait    <= '0;
                  sram_addr <= sram_addr + ADDR_W'(1);
                  r_rbuf    <= w_rword;
                  if (w_last_byte) begin
                     r_byte     <= '0;
                     r_word     <= r_word + c_len_w'(1);
                     r_rd_data  <= w_rword;
                     r_rd_valid <= 1'b1;
                  end else begin
                     r_byte <= r_byte + c_byte_w'(1);
                  end
               end else begin
                  r_wait <= r_wait + c_wait_w'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign sram_data     = w_drive ? w_wbyte : {MEM_DW{1'bz}};
   assign sram_ce_n     = w_ce_n;
   assign sram_we_n     = w_we_n;
   assign sram_oe_n     = w_oe_n;

   assign bus.req_ready = (r_state == S_IDLE) && !reset;
   assign bus.wr_ready  = w_wr_ready;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.rd_data   = r_rd_data;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
endmodule
`default_nettype wire

// File: tb/tb_sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_burst_ctrl
// Brief   : Self-checking bench with SRAM pin models and a byte-level reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_burst_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   sram_burst_ctrl_if #(.DATA_W(16), .ADDR_W(21), .LEN_W(3)) b0 ();
   sram_burst_ctrl_if #(.DATA_W(16), .ADDR_W(21), .LEN_W(3)) b1 ();

   wire  [7:0]  sd0, sd1;
   logic [20:0] sa0, sa1;
   logic        ce0, we0, oe0, ce1, we1, oe1;

   sram_burst_ctrl #(.DATA_W(16), .MEM_DW(8), .ADDR_W(21), .WAIT_CYC(0), .MAX_BURST(4)) u_dut0 (
      .clk(clk), .reset(reset), .bus(b0), .sram_data(sd0), .sram_addr(sa0),
      .sram_ce_n(ce0), .sram_we_n(we0), .sram_oe_n(oe0));

   sram_burst_ctrl #(.DATA_W(16), .MEM_DW(8), .ADDR_W(21), .WAIT_CYC(2), .MAX_BURST(4)) u_dut1 (
      .clk(clk), .reset(reset), .bus(b1), .sram_data(sd1), .sram_addr(sa1),
      .sram_ce_n(ce1), .sram_we_n(we1), .sram_oe_n(oe1));

   // Asynchronous SRAM pin models: combinational read, write captured while we_n is low.
   logic [7:0] mem0 [0:(1<<21)-1];
   logic [7:0] mem1 [0:(1<<21)-1];
   assign sd0 = (!ce0 && !oe0) ? mem0[sa0] : 8'hzz;
   assign sd1 = (!ce1 && !oe1) ? mem1[sa1] : 8'hzz;
   always @(posedge clk) if (!ce0 && !we0) mem0[sa0] = sd0;
   always @(posedge clk) if (!ce1 && !we1) mem1[sa1] = sd1;

   // Reference memory: byte address -> byte, filled from accepted write bursts.
   logic [7:0]  ref0 [int];

   logic [15:0] wbuf [4];
   int          stall [4];
   logic [15:0] rq [$];
   int          rcyc [$];
   int          done_cyc, we_low, we_fall, oe_low, stall_bad, wait_cyc;

   typedef struct packed {
      logic             wr;
      logic [20:0]      addr;
      logic [2:0]       len;
      logic [3:0][15:0] d;
      logic [7:0]       stall1;
      logic [7:0]       exp_done;
      logic [2:0]       exp_nrd;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [20:0] a, input logic [2:0] l,
                               input logic [15:0] d0, input logic [15:0] d1,
                               input logic [15:0] d2, input logic [15:0] d3,
                               input int st, input int ed, input int nr);
      vec_t v;
      v.wr = wr; v.addr = a; v.len = l;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
      v.stall1 = 8'(st); v.exp_done = 8'(ed); v.exp_nrd = 3'(nr);
      return v;
   endfunction

   function automatic int eff_len(input logic [2:0] l);
      if (l == 3'd0) return 1;
      if (l > 3'd4) return 4;
      return int'(l);
   endfunction

   function automatic logic [7:0] rb(input logic [20:0] a);
      return ref0.exists(int'(a)) ? ref0[int'(a)] : 8'h00;
   endfunction

   function automatic logic [15:0] ref_word(input logic [20:0] addr, input int w);
      logic [20:0] a0;
      a0 = addr + 21'(2 * w);
      return {rb(a0 + 21'd1), rb(a0)};
   endfunction

   task automatic ref_write(input logic [20:0] addr, input int n);
      logic [20:0] a;
      for (int w = 0; w < n; w++) begin
         for (int k = 0; k < 2; k++) begin
            a = addr + 21'(2 * w + k);
            ref0[int'(a)] = wbuf[w][8*k +: 8];
         end
      end
   endtask

   // Issues one request on DUT0 starting at a negedge; returns at the negedge of done.
   task automatic run_req(input logic wr, input logic [20:0] addr, input logic [2:0] len);
      int   n, wi, st;
      logic prev_we;
      rq.delete(); rcyc.delete();
      done_cyc = -1; we_low = 0; we_fall = 0; oe_low = 0; stall_bad = 0;
      b0.req_valid = 1'b1; b0.req_write = wr; b0.req_addr = addr; b0.req_len = len;
      n = 0;
      while (!b0.req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      wait_cyc = n;
      chk("accept bound", longint'(n < 10), 1);
      @(negedge clk);
      b0.req_valid = 1'b0;
      b0.req_write = ~wr;
      b0.req_addr  = 21'($urandom);
      b0.req_len   = 3'($urandom);
      wi = 0; st = stall[0]; prev_we = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         if (!we0) we_low++;
         if (prev_we && !we0) we_fall++;
         prev_we = we0;
         if (!oe0) oe_low++;
         if (b0.rd_valid) begin
            rq.push_back(b0.rd_data);
            rcyc.push_back(c);
         end
         b0.wr_valid = 1'b0;
         if (b0.wr_ready) begin
            if (st > 0) begin
               st--;
               if (we0 !== 1'b1 || ce0 !== 1'b0) stall_bad++;
            end else begin
               b0.wr_valid = 1'b1;
               b0.wr_data  = wbuf[wi & 3];
               wi++;
               st = (wi < 4) ? stall[wi] : 0;
            end
         end
         if (b0.done) begin
            done_cyc = c;
            break;
         end
         @(negedge clk);
      end
      b0.wr_valid = 1'b0;
   endtask

   // Latencies and data follow the word-level rules: write 1+2*(W+2) per word, read 2*(W+1).
   task automatic check_req(input string tag, input logic wr, input logic [20:0] addr,
                            input int n, input int stalls);
      chk({tag, " done cycle"}, done_cyc, wr ? (5 * n + 1 + stalls) : (2 * n + 1));
      if (wr) begin
         chk({tag, " we pulses"}, we_fall, 2 * n);
         chk({tag, " we low cycles"}, we_low, 2 * n);
         chk({tag, " stall strobes"}, stall_bad, 0);
         chk({tag, " rd count"}, rq.size(), 0);
         ref_write(addr, n);
      end else begin
         chk({tag, " oe low cycles"}, oe_low, 2 * n);
         chk({tag, " rd count"}, rq.size(), n);
         for (int i = 0; i < n && i < rq.size(); i++) begin
            chk($sformatf("%s rd data %0d", tag, i), rq[i], ref_word(addr, i));
            chk($sformatf("%s rd cycle %0d", tag, i), rcyc[i], 2 * (i + 1) + 1);
         end
      end
   endtask

   task automatic run1(input logic wr, input logic [20:0] a, input logic [15:0] d);
      rq.delete(); rcyc.delete();
      done_cyc = -1; we_low = 0; oe_low = 0;
      b1.req_valid = 1'b1; b1.req_write = wr; b1.req_addr = a; b1.req_len = 3'd1;
      chk("dut1 ready", b1.req_ready, 1);
      @(negedge clk);
      b1.req_valid = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (!we1) we_low++;
         if (!oe1) oe_low++;
         if (b1.rd_valid) begin
            rq.push_back(b1.rd_data);
            rcyc.push_back(c);
         end
         b1.wr_valid = b1.wr_ready;
         b1.wr_data  = d;
         if (b1.done) begin
            done_cyc = c;
            break;
         end
         @(negedge clk);
      end
      b1.wr_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        wr;
      logic [20:0] addr;
      logic [2:0]  len;
      int          n, stalls, seen;

      for (int i = 0; i < (1 << 21); i++) begin
         mem0[i] = 8'h00;
         mem1[i] = 8'h00;
      end
      b0.req_valid = 0; b0.req_write = 0; b0.req_addr = '0; b0.req_len = '0;
      b0.wr_valid = 0; b0.wr_data = '0;
      b1.req_valid = 0; b1.req_write = 0; b1.req_addr = '0; b1.req_len = '0;
      b1.wr_valid = 0; b1.wr_data = '0;

      tbl[0] = mk(1, 21'h000010, 3'd1, 16'hBEEF, 0, 0, 0, 0, 6, 0);
      tbl[1] = mk(0, 21'h000010, 3'd1, 16'hBEEF, 0, 0, 0, 0, 3, 1);
      tbl[2] = mk(1, 21'h1FFFFE, 3'd4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 21, 0);
      tbl[3] = mk(0, 21'h1FFFFE, 3'd4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 9, 4);
      tbl[4] = mk(1, 21'h000200, 3'd2, 16'hAAAA, 16'h5555, 0, 0, 3, 14, 0);
      tbl[5] = mk(0, 21'h000200, 3'd2, 16'hAAAA, 16'h5555, 0, 0, 0, 5, 2);
      tbl[6] = mk(1, 21'h000300, 3'd0, 16'h1234, 0, 0, 0, 0, 6, 0);
      tbl[7] = mk(0, 21'h1FFFFE, 3'd7, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 9, 4);
      tbl[8] = mk(0, 21'h000300, 3'd0, 16'h1234, 0, 0, 0, 0, 3, 1);

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst ce_n", ce0, 1);
      chk("rst we_n", we0, 1);
      chk("rst oe_n", oe0, 1);
      chk("rst addr", sa0, 0);
      chk("rst req_ready", b0.req_ready, 0);
      chk("rst wr_ready", b0.wr_ready, 0);
      chk("rst rd_valid", b0.rd_valid, 0);
      chk("rst rd_data", b0.rd_data, 0);
      chk("rst busy", b0.busy, 0);
      chk("rst done", b0.done, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle req_ready", b0.req_ready, 1);

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         for (int k = 0; k < 4; k++) begin
            wbuf[k]  = tbl[i].d[k];
            stall[k] = 0;
         end
         stall[1] = int'(tbl[i].stall1);
         run_req(tbl[i].wr, tbl[i].addr, tbl[i].len);
         n = eff_len(tbl[i].len);
         chk($sformatf("vec%0d done", i), done_cyc, tbl[i].exp_done);
         chk($sformatf("vec%0d nrd", i), rq.size(), tbl[i].exp_nrd);
         for (int j = 0; j < int'(tbl[i].exp_nrd) && j < rq.size(); j++)
            chk($sformatf("vec%0d data%0d", i, j), rq[j], tbl[i].d[j]);
         check_req($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, n,
                   tbl[i].wr ? int'(tbl[i].stall1) : 0);
         @(negedge clk);
      end
      chk("mem 0x10", mem0[21'h000010], 8'hEF);
      chk("mem 0x11", mem0[21'h000011], 8'hBE);
      chk("mem wrap 0x1FFFFF", mem0[21'h1FFFFF], 8'h11);
      chk("mem wrap 0x000000", mem0[21'h000000], 8'h22);
      chk("mem wrap 0x000005", mem0[21'h000005], 8'h44);

      // Request raised while done is high is accepted one cycle later
      wbuf[0] = 16'h5A5A;
      for (int k = 0; k < 4; k++) stall[k] = 0;
      run_req(1'b1, 21'h000400, 3'd1);
      check_req("b2b write", 1'b1, 21'h000400, 1, 0);
      chk("b2b ready during done", b0.req_ready, 0);
      run_req(1'b0, 21'h000400, 3'd1);
      chk("b2b wait", wait_cyc, 1);
      check_req("b2b read", 1'b0, 21'h000400, 1, 0);
      @(negedge clk);

      // Reset during word 1 of a 3-word read
      b0.req_valid = 1'b1; b0.req_write = 1'b0; b0.req_addr = 21'h1FFFFE; b0.req_len = 3'd3;
      @(negedge clk);
      b0.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort pre rd_valid", b0.rd_valid, 1);
      chk("abort pre rd_data", b0.rd_data, 16'h1111);
      reset = 1'b1;
      #1;
      chk("abort ce_n", ce0, 1);
      chk("abort oe_n", oe0, 1);
      chk("abort we_n", we0, 1);
      chk("abort busy", b0.busy, 0);
      chk("abort rd_valid", b0.rd_valid, 0);
      chk("abort req_ready", b0.req_ready, 0);
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (b0.done || b0.rd_valid) seen++;
      end
      reset = 1'b0;
      @(negedge clk);
      chk("abort ready after release", b0.req_ready, 1);
      repeat (3) begin
         if (b0.done || b0.rd_valid || !ce0) seen++;
         @(negedge clk);
      end
      chk("abort quiet", seen, 0);

      // Randomised bursts against the reference memory
      for (int r = 0; r < 40; r++) begin
         wr = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       addr = 21'h000100;
            1:       addr = 21'h1FFFF8;
            2:       addr = 21'h0ABCD0;
            default: addr = 21'h000000;
         endcase
         addr   = addr + 21'($urandom_range(0, 7));
         len    = 3'($urandom_range(0, 7));
         n      = eff_len(len);
         stalls = 0;
         for (int k = 0; k < 4; k++) begin
            wbuf[k]  = 16'($urandom);
            stall[k] = wr ? int'($urandom_range(0, 2)) : 0;
            if (k < n) stalls += stall[k];
         end
         run_req(wr, addr, len);
         check_req($sformatf("rnd%0d", r), wr, addr, n, stalls);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      @(negedge clk);

      // WAIT_CYC=2 instance
      run1(1'b1, 21'h000040, 16'hC0DE);
      chk("ws2 write done", done_cyc, 10);
      chk("ws2 we low cycles", we_low, 6);
      chk("ws2 mem 0x40", mem1[21'h000040], 8'hDE);
      chk("ws2 mem 0x41", mem1[21'h000041], 8'hC0);
      run1(1'b0, 21'h000040, 16'h0000);
      chk("ws2 read done", done_cyc, 7);
      chk("ws2 oe low cycles", oe_low, 6);
      chk("ws2 rd count", rq.size(), 1);
      if (rq.size() > 0) begin
         chk("ws2 rd data", rq[0], 16'hC0DE);
         chk("ws2 rd cycle", rcyc[0], 7);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
